// File: rtl/alu_issue_stage_pkg.sv
// Shared constants for the ID->EX issue stage: ALU control codes, MIPS
// opcode/funct encodings and the widths of the fields carried per issued op.
package alu_issue_stage_pkg;

  localparam int CTRL_W   = 4;
  localparam int OPCODE_W = 6;
  localparam int FUNCT_W  = 6;
  localparam int IMM_W    = 16;

  localparam logic [CTRL_W-1:0] ALU_AND = 4'h0;
  localparam logic [CTRL_W-1:0] ALU_OR  = 4'h1;
  localparam logic [CTRL_W-1:0] ALU_ADD = 4'h2;
  localparam logic [CTRL_W-1:0] ALU_ADDU = 4'h3;
  localparam logic [CTRL_W-1:0] ALU_SUB = 4'h6;
  localparam logic [CTRL_W-1:0] ALU_SLT = 4'h7;
  localparam logic [CTRL_W-1:0] ALU_NOR = 4'hC;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_ADDIU = 6'h09;
  localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

  localparam logic [FUNCT_W-1:0] FN_ADD  = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_ADDU = 6'h21;
  localparam logic [FUNCT_W-1:0] FN_SUB  = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_SUBU = 6'h23;
  localparam logic [FUNCT_W-1:0] FN_AND  = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR   = 6'h25;
  localparam logic [FUNCT_W-1:0] FN_NOR  = 6'h27;
  localparam logic [FUNCT_W-1:0] FN_SLT  = 6'h2A;

endpackage

// File: rtl/alu_issue_stage_skid.sv
// Generic main+skid register pair. in_ready is registered (= !skid valid);
// the skid entry only fills when an op arrives while main is held and stalled.
module pipe_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             r_main_v, r_skid_v;
  logic [WIDTH-1:0] r_main_d, r_skid_d;
  logic             w_acc, w_main_free;

  assign in_ready    = !r_skid_v;
  assign out_valid   = r_main_v;
  assign out_data    = r_main_d;
  assign w_acc       = in_valid && !r_skid_v;
  assign w_main_free = !r_main_v || out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_main_d <= '0;
      r_skid_d <= '0;
    end else if (flush) begin
      // flush wins over a same-cycle accept: the incoming op is dropped
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (w_main_free) begin
      if (r_skid_v) begin
        r_main_v <= 1'b1;
        r_main_d <= r_skid_d;
        r_skid_v <= 1'b0;
      end else begin
        r_main_v <= w_acc;
        if (w_acc) r_main_d <= in_data;
      end
    end else if (w_acc) begin
      r_skid_v <= 1'b1;
      r_skid_d <= in_data;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: decodes opcode/funct to an ALU control code, selects
// operand B and buffers the op behind a full-throughput skid handshake.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int                DATA_WIDTH     = 32,
  parameter int                REG_ADDR_WIDTH = 5,
  parameter logic [CTRL_W-1:0] CTRL_INVALID   = 4'hF
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OPCODE_W-1:0]       in_opcode,
  input  logic [FUNCT_W-1:0]        in_funct,
  input  logic [DATA_WIDTH-1:0]     in_rs_data,
  input  logic [DATA_WIDTH-1:0]     in_rt_data,
  input  logic [IMM_W-1:0]          in_imm16,
  input  logic [REG_ADDR_WIDTH-1:0] in_rt_idx,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd_idx,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_input_a,
  output logic [DATA_WIDTH-1:0]     out_input_b,
  output logic [CTRL_W-1:0]         out_control,
  output logic [REG_ADDR_WIDTH-1:0] out_dest_idx,
  output logic                      out_reg_write,
  output logic                      out_illegal
);

  localparam int EW = 2*DATA_WIDTH + CTRL_W + REG_ADDR_WIDTH + 2;

  logic [DATA_WIDTH-1:0]     w_ext, w_zext, w_b;
  logic [CTRL_W-1:0]         w_ctrl;
  logic [REG_ADDR_WIDTH-1:0] w_dest;
  logic                      w_wr, w_ill;
  logic [EW-1:0]             w_in_d, w_out_d;

  assign w_ext  = {{(DATA_WIDTH-IMM_W){in_imm16[IMM_W-1]}}, in_imm16};
  assign w_zext = {{(DATA_WIDTH-IMM_W){1'b0}}, in_imm16};

  always_comb begin
    w_ctrl = CTRL_INVALID;
    w_ill  = 1'b1;
    w_wr   = 1'b0;
    w_b    = in_rt_data;
    w_dest = '0;
    unique case (in_opcode)
      OP_RTYPE: begin
        w_ill  = 1'b0;
        w_wr   = 1'b1;
        w_dest = in_rd_idx;
        unique case (in_funct)
          FN_AND:          w_ctrl = ALU_AND;
          FN_OR:           w_ctrl = ALU_OR;
          FN_ADD:          w_ctrl = ALU_ADD;
          FN_ADDU:         w_ctrl = ALU_ADDU;
          FN_SUB, FN_SUBU: w_ctrl = ALU_SUB;
          FN_SLT:          w_ctrl = ALU_SLT;
          FN_NOR:          w_ctrl = ALU_NOR;
          default: begin
            w_ill  = 1'b1;
            w_wr   = 1'b0;
            w_dest = '0;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_LW: begin
        w_ill  = 1'b0;
        w_wr   = 1'b1;
        w_b    = w_ext;
        w_dest = in_rt_idx;
        w_ctrl = (in_opcode == OP_ADDI) ? ALU_ADD :
                 (in_opcode == OP_SLTI) ? ALU_SLT : ALU_ADDU;
      end
      OP_ANDI, OP_ORI: begin
        w_ill  = 1'b0;
        w_wr   = 1'b1;
        w_b    = w_zext;
        w_dest = in_rt_idx;
        w_ctrl = (in_opcode == OP_ANDI) ? ALU_AND : ALU_OR;
      end
      OP_SW: begin
        w_ill  = 1'b0;
        w_b    = w_ext;
        w_dest = in_rt_idx;
        w_ctrl = ALU_ADDU;
      end
      OP_BEQ: begin
        w_ill  = 1'b0;
        w_ctrl = ALU_SUB;
      end
      default: ;
    endcase
  end

  assign w_in_d = {in_rs_data, w_b, w_ctrl, w_dest, w_wr, w_ill};

  pipe_skid_buffer #(.WIDTH(EW)) u_buf (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_out_d)
  );

  assign {out_input_a, out_input_b, out_control, out_dest_idx, out_reg_write, out_illegal} = w_out_d;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: expectations queued at accept,
// compared on every output transfer by a negedge monitor.
module tb_alu_issue_stage;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  c;
    logic [4:0]  d;
    logic        w;
    logic        il;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [5:0]  in_opcode, in_funct;
  logic [31:0] in_rs_data, in_rt_data, out_input_a, out_input_b;
  logic [15:0] in_imm16;
  logic [4:0]  in_rt_idx, in_rd_idx, out_dest_idx;
  logic [3:0]  out_control;
  logic        out_reg_write, out_illegal;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e, mon_g;

  always #5 clock = ~clock;

  alu_issue_stage dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct(in_funct),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm16(in_imm16),
    .in_rt_idx(in_rt_idx), .in_rd_idx(in_rd_idx),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_input_a(out_input_a), .out_input_b(out_input_b), .out_control(out_control),
    .out_dest_idx(out_dest_idx), .out_reg_write(out_reg_write), .out_illegal(out_illegal)
  );

  // a transfer seen here completes on the following posedge
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      checks++;
      mon_g = {out_input_a, out_input_b, out_control, out_dest_idx, out_reg_write, out_illegal};
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got %h, expected nothing", mon_g);
      end else begin
        mon_e = sb.pop_front();
        if (mon_g !== mon_e) begin
          errors++;
          $display("FAIL sb_data: got a=%h b=%h c=%h d=%0d w=%b il=%b, expected a=%h b=%h c=%h d=%0d w=%b il=%b",
                   mon_g.a, mon_g.b, mon_g.c, mon_g.d, mon_g.w, mon_g.il,
                   mon_e.a, mon_e.b, mon_e.c, mon_e.d, mon_e.w, mon_e.il);
        end
      end
    end
  end

  function automatic exp_t mk(input logic [31:0] a, b, input logic [3:0] c,
                              input logic [4:0] d, input logic w, il);
    exp_t e;
    e.a = a; e.b = b; e.c = c; e.d = d; e.w = w; e.il = il;
    return e;
  endfunction

  task automatic drive(input logic [5:0] op, fn, input logic [31:0] rs, rt,
                       input logic [15:0] imm, input logic [4:0] rti, rdi);
    in_valid = 1'b1; in_opcode = op; in_funct = fn;
    in_rs_data = rs; in_rt_data = rt; in_imm16 = imm;
    in_rt_idx = rti; in_rd_idx = rdi;
  endtask

  task automatic send(input logic [5:0] op, fn, input logic [31:0] rs, rt,
                      input logic [15:0] imm, input logic [4:0] rti, rdi, input exp_t e);
    drive(op, fn, rs, rt, imm, rti, rdi);
    if (in_ready && !flush) sb.push_back(e);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drain_wait(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clock); n++;
    end
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d ops still pending, expected 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(6'h0, 6'h0, 32'h0, 32'h0, 16'h0, 5'h0, 5'h0);
    in_valid = 1'b0;
    idle(2);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_control !== 4'h0 ||
        out_input_b !== 32'h0 || out_reg_write !== 1'b0) begin
      errors++;
      $display("FAIL reset: got v=%b rdy=%b c=%h b=%h w=%b, expected v=0 rdy=1 c=0 b=0 w=0",
               out_valid, in_ready, out_control, out_input_b, out_reg_write);
    end
    reset_n = 1'b1;
    idle(1);
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    send(6'h00, 6'h20, 32'd5, 32'd7, 16'h1820, 5'd7, 5'd3, mk(32'd5, 32'd7, 4'h2, 5'd3, 1'b1, 1'b0));
    checks++;
    if (out_valid !== 1'b1 || out_input_a !== 32'd5 || out_input_b !== 32'd7 ||
        out_control !== 4'h2 || out_dest_idx !== 5'd3 || out_reg_write !== 1'b1) begin
      errors++;
      $display("FAIL add_latency: got v=%b a=%0d b=%0d c=%h d=%0d w=%b, expected v=1 a=5 b=7 c=2 d=3 w=1",
               out_valid, out_input_a, out_input_b, out_control, out_dest_idx, out_reg_write);
    end
    idle(1);
  endtask

  task automatic test_rtype_table();
    logic [5:0] fn [8];
    logic [3:0] cc [8];
    fn = '{6'h24, 6'h25, 6'h21, 6'h22, 6'h23, 6'h2A, 6'h27, 6'h20};
    cc = '{4'h0,  4'h1,  4'h3,  4'h6,  4'h6,  4'h7,  4'hC,  4'h2};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++)
      send(6'h00, fn[i], 32'h100 + i, 32'h200 + i, 16'h0, 5'd9, 5'(10 + i),
           mk(32'h100 + i, 32'h200 + i, cc[i], 5'(10 + i), 1'b1, 1'b0));
    // unsupported R-type funct (sll)
    send(6'h00, 6'h00, 32'h11, 32'h22, 16'h0, 5'd0, 5'd0, mk(32'h11, 32'h22, 4'hF, 5'd0, 1'b0, 1'b1));
    drain_wait("rtype");
  endtask

  task automatic test_imm();
    out_ready = 1'b1;
    send(6'h08, 6'h3F, 32'd10, 32'h5555, 16'hFFFF, 5'd4, 5'd31, mk(32'd10, 32'hFFFF_FFFF, 4'h2, 5'd4, 1'b1, 1'b0));
    send(6'h0C, 6'h3F, 32'd10, 32'h5555, 16'hFFFF, 5'd4, 5'd31, mk(32'd10, 32'h0000_FFFF, 4'h0, 5'd4, 1'b1, 1'b0));
    send(6'h0D, 6'h00, 32'd1, 32'd2, 16'h8000, 5'd6, 5'd1, mk(32'd1, 32'h0000_8000, 4'h1, 5'd6, 1'b1, 1'b0));
    send(6'h0A, 6'h00, 32'd1, 32'd2, 16'h8000, 5'd6, 5'd1, mk(32'd1, 32'hFFFF_8000, 4'h7, 5'd6, 1'b1, 1'b0));
    send(6'h09, 6'h00, 32'd3, 32'd2, 16'h7FFF, 5'd8, 5'd1, mk(32'd3, 32'h0000_7FFF, 4'h3, 5'd8, 1'b1, 1'b0));
    send(6'h23, 6'h00, 32'h1000, 32'd2, 16'h0004, 5'd12, 5'd1, mk(32'h1000, 32'h4, 4'h3, 5'd12, 1'b1, 1'b0));
    send(6'h2B, 6'h00, 32'h1000, 32'd2, 16'hFFFC, 5'd0, 5'd0, mk(32'h1000, 32'hFFFF_FFFC, 4'h3, 5'd0, 1'b0, 1'b0));
    send(6'h04, 6'h00, 32'd9, 32'd9, 16'h0010, 5'd0, 5'd0, mk(32'd9, 32'd9, 4'h6, 5'd0, 1'b0, 1'b0));
    drain_wait("imm");
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    send(6'h00, 6'h20, 32'hA1, 32'hB1, 16'h0, 5'd1, 5'd21, mk(32'hA1, 32'hB1, 4'h2, 5'd21, 1'b1, 1'b0));
    send(6'h00, 6'h25, 32'hA2, 32'hB2, 16'h0, 5'd2, 5'd22, mk(32'hA2, 32'hB2, 4'h1, 5'd22, 1'b1, 1'b0));
    drive(6'h00, 6'h24, 32'hA3, 32'hB3, 16'h0, 5'd3, 5'd23);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready: got in_ready=%b, expected 0", in_ready);
    end
    idle(2);
    checks++;
    if (out_valid !== 1'b1 || out_input_a !== 32'hA1 || out_control !== 4'h2) begin
      errors++;
      $display("FAIL b2b_hold: got v=%b a=%h c=%h, expected v=1 a=a1 c=2", out_valid, out_input_a, out_control);
    end
    // op3 is presented until it is taken, then all three must emerge in order
    sb.push_back(mk(32'hA3, 32'hB3, 4'h0, 5'd23, 1'b1, 1'b0));
    out_ready = 1'b1;
    begin
      int n = 0;
      while (!in_ready && n < 10) begin @(posedge clock); n++; #1; end
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    drain_wait("b2b");
  endtask

  task automatic test_illegal();
    out_ready = 1'b0;
    send(6'h3F, 6'h20, 32'h77, 32'h88, 16'h1234, 5'd0, 5'd0, mk(32'h77, 32'h88, 4'hF, 5'd0, 1'b0, 1'b1));
    checks++;
    if (out_valid !== 1'b1 || out_control !== 4'hF || out_illegal !== 1'b1 || out_reg_write !== 1'b0) begin
      errors++;
      $display("FAIL illegal: got v=%b c=%h il=%b w=%b, expected v=1 c=f il=1 w=0",
               out_valid, out_control, out_illegal, out_reg_write);
    end
    out_ready = 1'b1;
    drain_wait("illegal");
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(6'h00, 6'h20, 32'hC1, 32'hD1, 16'h0, 5'd1, 5'd1, mk(32'hC1, 32'hD1, 4'h2, 5'd1, 1'b1, 1'b0));
    send(6'h00, 6'h20, 32'hC2, 32'hD2, 16'h0, 5'd1, 5'd2, mk(32'hC2, 32'hD2, 4'h2, 5'd2, 1'b1, 1'b0));
    drive(6'h00, 6'h20, 32'hC3, 32'hD3, 16'h0, 5'd1, 5'd3);
    flush = 1'b1;
    idle(1);
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush: got v=%b rdy=%b, expected v=0 rdy=1", out_valid, in_ready);
    end
    // flush beats an accept with the main entry empty
    drive(6'h00, 6'h20, 32'hC4, 32'hD4, 16'h0, 5'd1, 5'd4);
    flush = 1'b1;
    idle(1);
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_accept: got v=%b, expected 0", out_valid);
    end
    out_ready = 1'b1;
    send(6'h0D, 6'h00, 32'hE0, 32'h0, 16'h00F0, 5'd7, 5'd0, mk(32'hE0, 32'hF0, 4'h1, 5'd7, 1'b1, 1'b0));
    drain_wait("flush");
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    send(6'h00, 6'h22, 32'hF1, 32'hF2, 16'h0, 5'd1, 5'd5, mk(32'hF1, 32'hF2, 4'h6, 5'd5, 1'b1, 1'b0));
    send(6'h00, 6'h22, 32'hF3, 32'hF4, 16'h0, 5'd1, 5'd6, mk(32'hF3, 32'hF4, 4'h6, 5'd6, 1'b1, 1'b0));
    #1 reset_n = 1'b0;
    #1;
    sb.delete();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_input_a !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: got v=%b rdy=%b a=%h, expected v=0 rdy=1 a=0", out_valid, in_ready, out_input_a);
    end
    idle(1);
    reset_n = 1'b1;
    out_ready = 1'b1;
    send(6'h00, 6'h27, 32'h5, 32'h6, 16'h0, 5'd1, 5'd9, mk(32'h5, 32'h6, 4'hC, 5'd9, 1'b1, 1'b0));
    drain_wait("post_reset");
  endtask

  initial begin
    test_reset();
    test_add();
    test_imm();
    test_rtype_table();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_async_reset();
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
